// File: rtl/adder_error_monitor_if.sv
// Pair-in / metrics-out bus between the prefix adders, the error monitor and its consumer.
// master drives pairs and res_ready; slave (the monitor) drives in_ready and the metrics.
interface adder_error_monitor_if #(
  parameter int W         = 17,
  parameter int N_SAMPLES = 1024,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1),
  parameter int ACC_W     = W + CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     exact_sum;
  logic [W-1:0]     approx_sum;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [W-1:0]     max_ed;

  modport master (
    output in_valid, exact_sum, approx_sum, res_ready,
    input  in_ready, res_valid, err_count, sum_ed, max_ed
  );

  modport slave (
    input  in_valid, exact_sum, approx_sum, res_ready,
    output in_ready, res_valid, err_count, sum_ed, max_ed
  );
endinterface

// File: rtl/adder_error_monitor.sv
// Windowed exact-vs-approximate adder error metrics; 2-stage pipe, 1 pair/cycle,
// in_ready drops once the window is full, metrics held in DONE until res_ready.
module adder_error_monitor #(
  parameter int W         = 17,
  parameter int N_SAMPLES = 1024,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1),
  parameter int ACC_W     = W + CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  adder_error_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(N_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_ed_q, s1_ed_d;
  logic             s1_err_q, s1_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [W-1:0]     max_ed_q, max_ed_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             hs;
  logic [W-1:0]     ed;

  always_comb begin
    state_d     = state_q;
    accepted_d  = accepted_q;
    s1_valid_d  = 1'b0;
    s1_ed_d     = s1_ed_q;
    s1_err_d    = s1_err_q;
    err_count_d = err_count_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;
    res_valid_d = 1'b0;
    hs          = bus.in_valid && in_ready_q;
    ed          = (bus.exact_sum >= bus.approx_sum) ? (bus.exact_sum - bus.approx_sum)
                                                    : (bus.approx_sum - bus.exact_sum);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          accepted_d  = '0;
          err_count_d = '0;
          sum_ed_d    = '0;
          max_ed_d    = '0;
        end
      end
      S_RUN: begin
        if (hs) begin
          s1_valid_d = 1'b1;
          s1_ed_d    = ed;
          s1_err_d   = (bus.exact_sum != bus.approx_sum);
          accepted_d = accepted_q + CNT_W'(1);
        end
        if (s1_valid_q) begin
          sum_ed_d    = sum_ed_q + ACC_W'(s1_ed_q);
          err_count_d = err_count_q + CNT_W'(s1_err_q);
          if (s1_ed_q > max_ed_q) max_ed_d = s1_ed_q;
          // accepted only reaches N_FULL on the final handshake, so this is the last pair
          if (accepted_q == N_FULL) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // res_valid lags entry into DONE by one cycle; leave only once it has been seen
        if (res_valid_q && bus.res_ready) state_d = S_IDLE;
        else                              res_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RUN) && (accepted_d < N_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      accepted_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_ed_q     <= '0;
      s1_err_q    <= 1'b0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      accepted_q  <= accepted_d;
      s1_valid_q  <= s1_valid_d;
      s1_ed_q     <= s1_ed_d;
      s1_err_q    <= s1_err_d;
      err_count_q <= err_count_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.err_count = err_count_q;
  assign bus.sum_ed    = sum_ed_q;
  assign bus.max_ed    = max_ed_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor (N_SAMPLES=4): transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized windows.
module tb_adder_error_monitor;
  localparam int W  = 17;
  localparam int NS = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;

  adder_error_monitor_if #(.W(W), .N_SAMPLES(NS)) bus ();

  adder_error_monitor #(.W(W), .N_SAMPLES(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Model: mode 0=idle 1=run 2=done; window kept as lists of EDs and handshake edge numbers.
  int cyc = 0;
  int m_mode = 0;
  int ed_q[$];
  int hs_q[$];

  function automatic bit exp_in_ready();
    return (m_mode == 1) && (ed_q.size() < NS);
  endfunction

  function automatic bit exp_res_valid();
    return (m_mode == 2) && (hs_q.size() == NS) && (cyc >= hs_q[NS-1] + 2);
  endfunction

  always @(posedge clk) begin
    bit ir, rv;
    int e, a;
    ir = exp_in_ready();
    rv = exp_res_valid();
    cyc++;
    if (!rst_n) begin
      m_mode = 0;
      ed_q.delete();
      hs_q.delete();
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode = 1;
          ed_q.delete();
          hs_q.delete();
        end
        1: begin
          if (ed_q.size() == NS && hs_q[NS-1] == cyc - 1) m_mode = 2;
          if (bus.in_valid && ir) begin
            e = int'(bus.exact_sum);
            a = int'(bus.approx_sum);
            ed_q.push_back(e >= a ? e - a : a - e);
            hs_q.push_back(cyc);
          end
        end
        default: if (rv && bus.res_ready) m_mode = 0;
      endcase
    end
  end

  // Pairs become visible in the metrics one edge after their handshake.
  always @(negedge clk) begin
    int x_err, x_sum, x_max;
    if (cyc > 0) begin
      x_err = 0; x_sum = 0; x_max = 0;
      for (int i = 0; i < ed_q.size(); i++) begin
        if (hs_q[i] < cyc) begin
          if (ed_q[i] != 0) x_err++;
          x_sum += ed_q[i];
          if (ed_q[i] > x_max) x_max = ed_q[i];
        end
      end
      check("in_ready",  32'(bus.in_ready),  32'(exp_in_ready()));
      check("res_valid", 32'(bus.res_valid), 32'(exp_res_valid()));
      check("busy",      32'(busy),          32'(m_mode != 0));
      check("err_count", 32'(bus.err_count), 32'(x_err));
      check("sum_ed",    32'(bus.sum_ed),    32'(x_sum));
      check("max_ed",    32'(bus.max_ed),    32'(x_max));
    end
  end

  int last_hs = 0;
  int lat = 0;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [W-1:0] pe[4] = '{17'd3, 17'd1, 17'd2, 17'd0};
  logic [W-1:0] pa[4] = '{17'd1, 17'd3, 17'd2, 17'd0};

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] e, input logic [W-1:0] a);
    int t;
    bus.in_valid   = 1'b1;
    bus.exact_sum  = e;
    bus.approx_sum = a;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("send_pair");
    @(negedge clk);
    last_hs = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(output int l);
    int t;
    t = 0;
    while (!bus.res_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) timeout("wait_res");
    l = cyc - last_hs;
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic check_metrics(input string tag, input int ec, input int se, input int me);
    check({tag, "_err_count"}, 32'(bus.err_count), 32'(ec));
    check({tag, "_sum_ed"},    32'(bus.sum_ed),    32'(se));
    check({tag, "_max_ed"},    32'(bus.max_ed),    32'(me));
  endtask

  initial begin
    logic [W-1:0] re, ra;
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.exact_sum  = '0;
    bus.approx_sum = '0;
    bus.res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);
    check_metrics("reset", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: identical results only
    do_start();
    send_pair(17'h00000, 17'h00000);
    send_pair(17'h1FFFF, 17'h1FFFF);
    send_pair(17'h12345, 17'h12345);
    send_pair(17'h00001, 17'h00001);
    wait_res(lat);
    check("t1_latency", 32'(lat), 32'd2);
    check_metrics("t1", 0, 0, 0);
    ack();

    // 2: mixed errors including full-scale distance
    do_start();
    send_pair(17'd10, 17'd7);
    send_pair(17'd7, 17'd10);
    send_pair(17'd100, 17'd100);
    send_pair(17'h1FFFF, 17'h00000);
    wait_res(lat);
    check("t2_latency", 32'(lat), 32'd2);
    check_metrics("t2", 3, 32'h20005, 32'h1FFFF);
    ack();

    // 3: bubbles, then a 5th pair offered once the window is full
    do_start();
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        bus.in_valid = pat[i][0];
        if (pat[i] == 1) begin
          bus.exact_sum  = pe[k];
          bus.approx_sum = pa[k];
          k++;
        end else begin
          bus.exact_sum  = W'($urandom_range(0, 131071));
          bus.approx_sum = W'($urandom_range(0, 131071));
        end
        @(negedge clk);
      end
      last_hs = cyc;
    end
    bus.in_valid   = 1'b1;
    bus.exact_sum  = 17'h1FFFF;
    bus.approx_sum = 17'h00000;
    repeat (3) begin
      check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_res(lat);
    check_metrics("t3", 2, 4, 2);

    // 4: consumer stalls in DONE while start is pulsed
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check("t4_res_valid_held", 32'(bus.res_valid), 32'd1);
    check("t4_busy_held", 32'(busy), 32'd1);
    check_metrics("t4", 2, 4, 2);
    ack();
    check("t4_busy_after_ack", 32'(busy), 32'd0);
    check("t4_res_valid_after_ack", 32'(bus.res_valid), 32'd0);
    check_metrics("t4_idle_hold", 2, 4, 2);

    // 5: reset mid-window
    do_start();
    send_pair(17'd50, 17'd0);
    send_pair(17'd0, 17'd60);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(bus.in_ready), 32'd0);
    check("t5_res_valid", 32'(bus.res_valid), 32'd0);
    check_metrics("t5_rst", 0, 0, 0);
    do_start();
    repeat (4) send_pair(17'd5, 17'd1);
    wait_res(lat);
    check_metrics("t5_new", 4, 16, 4);
    ack();

    // 6: start and in_valid together in IDLE
    start          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.exact_sum  = 17'd20;
    bus.approx_sum = 17'd0;
    check("t6_in_ready_idle", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    send_pair(17'd20, 17'd0);
    send_pair(17'd0, 17'd3);
    send_pair(17'd1, 17'd1);
    send_pair(17'd9, 17'd9);
    wait_res(lat);
    check_metrics("t6", 2, 23, 20);
    ack();

    // randomized windows, checked by the model only
    for (int w = 0; w < 8; w++) begin
      bus.in_valid = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.in_valid = 1'b0;
      do_start();
      for (int p = 0; p < NS; p++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.exact_sum  = W'($urandom_range(0, 131071));
          bus.approx_sum = W'($urandom_range(0, 131071));
          @(negedge clk);
        end
        re = W'($urandom_range(0, 131071));
        case ($urandom_range(0, 3))
          0:       ra = re;
          1:       ra = re ^ W'($urandom_range(1, 15));
          default: ra = W'($urandom_range(0, 131071));
        endcase
        send_pair(re, ra);
      end
      wait_res(lat);
      check("rnd_latency", 32'(lat), 32'd2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
